audio_lj_master_tx: RTL and testbench



---
 rtl/audio_lj_master_tx_pkg.sv | 30 +++
 rtl/audio_lj_master_tx_if.sv | 36 +++
 rtl/audio_lj_master_tx_bclk_gen.sv | 51 +++++
 rtl/audio_lj_master_tx.sv | 158 +++++++++++++++
 tb/tb_audio_lj_master_tx.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_lj_master_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared constants, state encoding and sample-justification
//               helper for the left-justified audio master transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int AUDIO_SLOT_BITS          = 32;
    localparam int AUDIO_FRAME_BITS         = 64;
    localparam int DEFAULT_AUDIO_DATA_WIDTH = 29;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } audio_state_t;

    // Moves a zero-extended sample so its MSB lands in slot 0 of a half frame;
    // the slots after the last sample bit fall out as zeros.
    function automatic logic [AUDIO_SLOT_BITS-1:0] left_justify(
        input logic [AUDIO_SLOT_BITS-1:0] sample,
        input int                         width
    );
        return sample << (AUDIO_SLOT_BITS - width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_lj_master_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_lj_master_tx_if
// Description : Sample-producer handshake: stereo sample pair, write strobe
//               and the holding-buffer-empty indication.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_lj_master_tx_if
    import audio_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = DEFAULT_AUDIO_DATA_WIDTH
);

    logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_out;
    logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_out;
    logic                        write_audio_out;
    logic                        audio_out_allowed;

    // Sample producer side.
    modport master (
        output left_channel_audio_out,
        output right_channel_audio_out,
        output write_audio_out,
        input  audio_out_allowed
    );

    // Transmitter side.
    modport slave (
        input  left_channel_audio_out,
        input  right_channel_audio_out,
        input  write_audio_out,
        output audio_out_allowed
    );

endinterface
`default_nettype wire

// File: rtl/audio_lj_master_tx_bclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : audio_bclk_gen
// Description : Divides CLOCK_50 into the bit clock. The divider is held at 0
//               with BCLK low while not running, so the first BCLK rise comes
//               exactly BCLK_DIV cycles after run goes high.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_bclk_gen #(
    parameter int BCLK_DIV = 16
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic run,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);

    localparam int               DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    logic             w_terminal;

    // Strobes are combinational so the consumer updates its registers on the
    // same clock edge that the BCLK register toggles.
    assign w_terminal = run && (r_div == C_DIV_LAST);
    assign bclk_rise  = w_terminal && !r_bclk;
    assign bclk_fall  = w_terminal && r_bclk;
    assign bclk       = r_bclk;

    // Half-period divider; toggles BCLK at terminal count.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (!run) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_terminal) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_lj_master_tx.sv
`default_nettype none
// ============================================================================
// Module      : audio_lj_master_tx
// Description : Clock-master left-justified stereo transmitter. Owns BCLK and
//               LRCK, shifts a 64-slot frame MSB first, and decouples the
//               sample producer with a one-frame holding buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_lj_master_tx
    import audio_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = DEFAULT_AUDIO_DATA_WIDTH,
    parameter int BCLK_DIV         = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 enable,
    audio_lj_master_tx_if.slave  aud,
    output logic                 AUD_BCLK,
    output logic                 AUD_LRCK,
    output logic                 AUD_DACDAT,
    output logic                 underflow,
    output logic [7:0]           underflow_count
);

    localparam logic [5:0] C_LAST_SLOT      = 6'(AUDIO_FRAME_BITS - 1);
    localparam logic [5:0] C_LAST_LEFT_SLOT = 6'(AUDIO_SLOT_BITS - 1);

    audio_state_t                  r_state;
    logic [5:0]                    r_slot;
    logic [AUDIO_FRAME_BITS-1:0]   r_shift;
    logic                          r_lrck;
    logic                          r_dacdat;
    logic [AUDIO_FRAME_BITS-1:0]   r_buf;
    logic                          r_full;
    logic                          r_allowed;
    logic                          r_underflow;
    logic [7:0]                    r_uf_count;

    logic                          w_bclk;
    logic                          w_bclk_fall;
    logic                          w_unused_bclk_rise;
    logic                          w_run;
    logic                          w_accept;
    logic                          w_frame_end;
    logic                          w_frame_start;
    logic                          w_underflow;
    logic                          w_full_next;
    logic [AUDIO_FRAME_BITS-1:0]   w_wr_frame;
    logic [AUDIO_FRAME_BITS-1:0]   w_next_frame;

    assign w_run = (r_state != IDLE);

    audio_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .run       (w_run),
        .bclk      (w_bclk),
        .bclk_rise (w_unused_bclk_rise),
        .bclk_fall (w_bclk_fall)
    );

    // Incoming pair already laid out as a full frame: left half then right half.
    assign w_wr_frame = {left_justify(AUDIO_SLOT_BITS'(aud.left_channel_audio_out),  AUDIO_DATA_WIDTH),
                         left_justify(AUDIO_SLOT_BITS'(aud.right_channel_audio_out), AUDIO_DATA_WIDTH)};

    assign w_accept      = aud.write_audio_out && r_allowed;
    assign w_frame_end   = w_bclk_fall && (r_slot == C_LAST_SLOT);
    // A frame boundary with enable low is where the link stops instead.
    assign w_frame_start = enable && (((r_state == IDLE)) || w_frame_end);

    // Buffered data wins; otherwise a write landing on the load itself is
    // forwarded straight into the shifter and counts as a timely sample.
    assign w_next_frame = r_full   ? r_buf      :
                          w_accept ? w_wr_frame : '0;
    assign w_underflow  = w_frame_start && !r_full && !w_accept;
    assign w_full_next  = w_frame_start ? 1'b0 : (r_full || w_accept);

    // Link state machine: frame loads, slot sequencing, LRCK and serial data.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_slot   <= '0;
            r_shift  <= '0;
            r_lrck   <= 1'b0;
            r_dacdat <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_frame_start) begin
                        r_state  <= RUN;
                        r_slot   <= '0;
                        r_lrck   <= 1'b1;
                        r_dacdat <= w_next_frame[AUDIO_FRAME_BITS-1];
                        r_shift  <= w_next_frame << 1;
                    end
                end
                RUN, STOPPING: begin
                    r_state <= enable ? RUN : STOPPING;
                    if (w_frame_start) begin
                        r_slot   <= '0;
                        r_lrck   <= 1'b1;
                        r_dacdat <= w_next_frame[AUDIO_FRAME_BITS-1];
                        r_shift  <= w_next_frame << 1;
                    end else if (w_frame_end) begin
                        r_state  <= IDLE;
                        r_slot   <= '0;
                        r_lrck   <= 1'b0;
                        r_dacdat <= 1'b0;
                        r_shift  <= '0;
                    end else if (w_bclk_fall) begin
                        r_slot   <= r_slot + 6'd1;
                        r_dacdat <= r_shift[AUDIO_FRAME_BITS-1];
                        r_shift  <= r_shift << 1;
                        if (r_slot == C_LAST_LEFT_SLOT) begin
                            r_lrck <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Holding buffer, handshake flag and underflow accounting.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_buf       <= '0;
            r_full      <= 1'b0;
            r_allowed   <= 1'b0;
            r_underflow <= 1'b0;
            r_uf_count  <= '0;
        end else begin
            r_underflow <= w_underflow;
            if (w_underflow && (r_uf_count != 8'hFF)) begin
                r_uf_count <= r_uf_count + 8'd1;
            end
            if (w_accept && !w_frame_start) begin
                r_buf <= w_wr_frame;
            end
            r_full    <= w_full_next;
            r_allowed <= !w_full_next;
        end
    end

    assign AUD_BCLK              = w_bclk;
    assign AUD_LRCK              = r_lrck;
    assign AUD_DACDAT            = r_dacdat;
    assign underflow             = r_underflow;
    assign underflow_count       = r_uf_count;
    assign aud.audio_out_allowed = r_allowed;

endmodule
`default_nettype wire

// File: tb/tb_audio_lj_master_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_lj_master_tx
// Description : Directed self-checking bench for audio_lj_master_tx. A second
//               instance with the fastest divider runs free to reach the
//               underflow counter's saturation point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_lj_master_tx;

    localparam int W         = 29;
    localparam int DIV       = 4;
    localparam int FRAME_CYC = 128 * DIV;
    localparam int SAT_DIV   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic       reset_n, enable;
    logic       bclk, lrck, dacdat, uf;
    logic [7:0] uf_cnt;

    logic       sat_reset_n, sat_enable;
    logic       sat_bclk, sat_lrck, sat_dacdat, sat_uf;
    logic [7:0] sat_uf_cnt;
    int         sat_start;

    audio_lj_master_tx_if #(.AUDIO_DATA_WIDTH(W)) aud ();
    audio_lj_master_tx_if #(.AUDIO_DATA_WIDTH(W)) sat_aud ();

    audio_lj_master_tx #(.AUDIO_DATA_WIDTH(W), .BCLK_DIV(DIV)) u_dut (
        .CLOCK_50        (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .aud             (aud),
        .AUD_BCLK        (bclk),
        .AUD_LRCK        (lrck),
        .AUD_DACDAT      (dacdat),
        .underflow       (uf),
        .underflow_count (uf_cnt)
    );

    audio_lj_master_tx #(.AUDIO_DATA_WIDTH(W), .BCLK_DIV(SAT_DIV)) u_sat (
        .CLOCK_50        (clk),
        .reset_n         (sat_reset_n),
        .enable          (sat_enable),
        .aud             (sat_aud),
        .AUD_BCLK        (sat_bclk),
        .AUD_LRCK        (sat_lrck),
        .AUD_DACDAT      (sat_dacdat),
        .underflow       (sat_uf),
        .underflow_count (sat_uf_cnt)
    );

    // Per-frame plan: up to two writes and enable edges, by cycle in frame.
    int         p_wr_at [2];
    logic [W-1:0] p_wr_l [2];
    logic [W-1:0] p_wr_r [2];
    int         p_off_at, p_on_at;
    logic       last_allowed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plan_clear();
        p_wr_at[0] = -1;
        p_wr_at[1] = -1;
        p_wr_l[0]  = '0;
        p_wr_l[1]  = '0;
        p_wr_r[0]  = '0;
        p_wr_r[1]  = '0;
        p_off_at   = -1;
        p_on_at    = -1;
    endtask

    task automatic put(input logic [W-1:0] l, input logic [W-1:0] r);
        aud.left_channel_audio_out  = l;
        aud.right_channel_audio_out = r;
        aud.write_audio_out         = 1'b1;
    endtask

    // Observes one frame starting at its load cycle; bits are taken on BCLK
    // rises. Returns at the next frame's load cycle.
    task automatic run_frame(input string name, input logic [63:0] exp_bits, input int exp_uf);
        logic [63:0] got;
        int          hi, ufs, rises;
        logic        prev;
        got = '0; hi = 0; ufs = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (lrck) hi++;
            if (uf) ufs++;
            if (bclk && !prev) begin
                got = {got[62:0], dacdat};
                rises++;
            end
            prev = bclk;
            if (i == FRAME_CYC - 1) last_allowed = aud.audio_out_allowed;
            for (int k = 0; k < 2; k++) begin
                if (i == p_wr_at[k]) put(p_wr_l[k], p_wr_r[k]);
            end
            if (i == p_off_at) enable = 1'b0;
            if (i == p_on_at)  enable = 1'b1;
            tick();
            aud.write_audio_out = 1'b0;
        end
        chk({name, "_bits"},    got,   exp_bits);
        chk({name, "_rises"},   64'(rises), 64'd64);
        chk({name, "_lrck_hi"}, 64'(hi),    64'd256);
        chk({name, "_uf"},      64'(ufs),   64'(exp_uf));
        plan_clear();
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        sat_reset_n = 1'b0;
        sat_enable  = 1'b0;
        sat_start   = 0;
        last_allowed = 1'b0;
        aud.left_channel_audio_out      = '0;
        aud.right_channel_audio_out     = '0;
        aud.write_audio_out             = 1'b0;
        sat_aud.left_channel_audio_out  = '0;
        sat_aud.right_channel_audio_out = '0;
        sat_aud.write_audio_out         = 1'b0;
        plan_clear();
        repeat (3) tick();

        // Reset state
        chk("rst_bclk",    64'(bclk),   64'd0);
        chk("rst_lrck",    64'(lrck),   64'd0);
        chk("rst_dacdat",  64'(dacdat), 64'd0);
        chk("rst_uf",      64'(uf),     64'd0);
        chk("rst_uf_cnt",  64'(uf_cnt), 64'd0);
        chk("rst_allowed", 64'(aud.audio_out_allowed), 64'd0);

        reset_n     = 1'b1;
        sat_reset_n = 1'b1;
        sat_enable  = 1'b1;
        sat_start   = cyc;
        tick();
        chk("allowed_after_reset", 64'(aud.audio_out_allowed), 64'd1);

        // Buffered sample A, then start-up
        put(29'h0AAAAAAA, 29'h15555555);
        tick();
        aud.write_audio_out = 1'b0;
        chk("allowed_after_write", 64'(aud.audio_out_allowed), 64'd0);
        chk("idle_bclk",           64'(bclk),                  64'd0);
        enable = 1'b1;
        tick();
        chk("start_lrck",    64'(lrck),   64'd1);
        chk("start_bclk",    64'(bclk),   64'd0);
        chk("start_dacdat",  64'(dacdat), 64'd0);
        chk("start_uf",      64'(uf),     64'd0);
        chk("start_allowed", 64'(aud.audio_out_allowed), 64'd1);

        // Frame 1 carries A; B is buffered, C arrives while full and is dropped
        p_wr_at[0] = 100; p_wr_l[0] = 29'h12345678; p_wr_r[0] = 29'h0FEDCBA9;
        p_wr_at[1] = 200; p_wr_l[1] = 29'h1FFFFFFF; p_wr_r[1] = 29'h1FFFFFFF;
        run_frame("f1", 64'h55555550_AAAAAAA8, 0);
        chk("f1_allowed_end", 64'(last_allowed), 64'd0);
        chk("f2_start_allowed", 64'(aud.audio_out_allowed), 64'd1);
        chk("f2_start_cnt",     64'(uf_cnt), 64'd0);

        run_frame("f2", 64'h91A2B3C0_7F6E5D48, 0);
        chk("f3_start_uf",  64'(uf),     64'd1);
        chk("f3_start_cnt", 64'(uf_cnt), 64'd1);

        run_frame("f3", 64'h0, 1);
        chk("f4_start_cnt", 64'(uf_cnt), 64'd2);

        // Write D lands on the frame-5 load with the buffer empty
        p_wr_at[0] = FRAME_CYC - 1; p_wr_l[0] = 29'h00000001; p_wr_r[0] = 29'h10000000;
        run_frame("f4", 64'h0, 1);
        chk("f5_start_uf",      64'(uf),     64'd0);
        chk("f5_start_cnt",     64'(uf_cnt), 64'd2);
        chk("f5_start_allowed", 64'(aud.audio_out_allowed), 64'd1);

        // Enable dropped at slot 10, restored at slot 40; E buffered
        p_off_at = 80; p_on_at = 320;
        p_wr_at[0] = 150; p_wr_l[0] = 29'h1C3C3C3C; p_wr_r[0] = 29'h00F0F0F0;
        run_frame("f5", 64'h00000008_80000000, 0);
        chk("f6_start_lrck", 64'(lrck),   64'd1);
        chk("f6_start_uf",   64'(uf),     64'd0);
        chk("f6_start_cnt",  64'(uf_cnt), 64'd2);

        // Enable dropped at slot 10 for good: frame completes, then idle
        p_off_at = 80;
        run_frame("f6", 64'hE1E1E1E0_07878780, 0);
        chk("stop_bclk",   64'(bclk),   64'd0);
        chk("stop_lrck",   64'(lrck),   64'd0);
        chk("stop_dacdat", 64'(dacdat), 64'd0);
        repeat (20) tick();
        chk("idle_hold_bclk", 64'(bclk),   64'd0);
        chk("idle_hold_lrck", 64'(lrck),   64'd0);
        chk("idle_hold_cnt",  64'(uf_cnt), 64'd2);

        // Mid-frame asynchronous reset with a sample also waiting in the buffer
        put(29'h1ABCDEF1, 29'h00000F0F);
        tick();
        aud.write_audio_out = 1'b0;
        enable = 1'b1;
        tick();
        chk("f7_start_dacdat", 64'(dacdat), 64'd1);
        put(29'h00001234, 29'h00005678);
        tick();
        aud.write_audio_out = 1'b0;
        chk("f7_buf_allowed", 64'(aud.audio_out_allowed), 64'd0);
        repeat (172) tick();
        chk("pre_rst_bclk",   64'(bclk),   64'd1);
        chk("pre_rst_lrck",   64'(lrck),   64'd1);
        chk("pre_rst_dacdat", 64'(dacdat), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_bclk",    64'(bclk),   64'd0);
        chk("async_rst_lrck",    64'(lrck),   64'd0);
        chk("async_rst_dacdat",  64'(dacdat), 64'd0);
        chk("async_rst_cnt",     64'(uf_cnt), 64'd0);
        chk("async_rst_allowed", 64'(aud.audio_out_allowed), 64'd0);
        enable = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("rerst_allowed", 64'(aud.audio_out_allowed), 64'd1);
        chk("rerst_cnt",     64'(uf_cnt), 64'd0);
        chk("rerst_lrck",    64'(lrck),   64'd0);

        // Three starved frames
        enable = 1'b1;
        tick();
        chk("u1_start_uf",  64'(uf),     64'd1);
        chk("u1_start_cnt", 64'(uf_cnt), 64'd1);
        run_frame("u1", 64'h0, 1);
        run_frame("u2", 64'h0, 1);
        chk("u3_start_cnt", 64'(uf_cnt), 64'd3);
        p_off_at = 0;
        run_frame("u3", 64'h0, 1);
        chk("u_end_cnt",  64'(uf_cnt), 64'd3);
        chk("u_end_lrck", 64'(lrck),   64'd0);

        // Free-running starved instance: 260 frame loads must saturate at 255
        while (cyc < sat_start + 260 * 128 * SAT_DIV + 8) tick();
        chk("sat_cnt", 64'(sat_uf_cnt), 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
